hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Central stall/flush/bubble controller for the 5-stage MIPS pipeline.
- Drives the hold, flush and bubble controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB from three sources:
  - load-use hazard detection between ID and EX;
  - taken branches resolved in ID;
  - a fixed-latency data-memory access FSM in MEM.
- Also keeps a saturating count of stall cycles for performance measurement.

Parameters:
- MEM_LAT, 2, data-memory access latency in cycles (>=1); an access stalls the pipeline for MEM_LAT-1 cycles.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- IDEX_MemRead_i  in  1  load instruction currently in EX.
- IDEX_RegAddrRt_i  in  5  destination (rt) of the instruction in EX.
- IFID_RegAddrRs_i  in  5  rs of the instruction in ID.
- IFID_RegAddrRt_i  in  5  rt of the instruction in ID.
- Branch_taken_i  in  1  branch resolved taken in ID this cycle.
- EXMEM_MemAccess_i  in  1  load or store currently in MEM.
- PCWrite_o  out  1  PC update enable.
- IFID_Stall_o  out  1  IF/ID hold.
- IFID_Flush_o  out  1  IF/ID clear to NOP.
- IDEX_Stall_o  out  1  ID/EX hold; drives the ID/EX Stall_i input.
- IDEX_Bubble_o  out  1  select zero WB/M/EX control into ID/EX.
- EXMEM_Stall_o  out  1  EX/MEM hold.
- MEMWB_Bubble_o  out  1  clear WB control into MEM/WB.
- MemStall_o  out  1  memory stall active (status).
- StallCnt_o  out  CNT_W  stall cycles since reset, saturating.

Behaviour:
- All control outputs are combinational from state, counter and current inputs, so they act on the same rising edge. State, counter and StallCnt_o are registered.
- Reset (rst_i=1 at a rising edge):
  - state <= RUN, cnt <= 0, StallCnt_o <= 0.
  - While rst_i is high: PCWrite_o=1 and every other control output is 0, regardless of inputs.
  - Reset mid-stall abandons the access; no stall is asserted afterwards until a new EXMEM_MemAccess_i is seen in RUN.
- Memory stall signal: mem_stall = (state==RUN && EXMEM_MemAccess_i && MEM_LAT>1) || (state==WAIT && cnt!=0).
- FSM state RUN:
  - If EXMEM_MemAccess_i && MEM_LAT>1: cnt <= MEM_LAT-2 and state <= WAIT.
  - Otherwise stay in RUN.
- FSM state WAIT:
  - If cnt!=0: cnt <= cnt-1.
  - If cnt==0: mem_stall=0 for this cycle (the access completes) and state <= RUN.
  - EXMEM_MemAccess_i is ignored in WAIT.
  - A back-to-back access is detected in RUN on the following cycle.
- The resulting stall length is exactly MEM_LAT-1 cycles per access. MEM_LAT=1 never stalls.
- load_use = IDEX_MemRead_i && IDEX_RegAddrRt_i!=0 && (IDEX_RegAddrRt_i==IFID_RegAddrRs_i || IDEX_RegAddrRt_i==IFID_RegAddrRt_i).
- Priority, mem_stall first:
  - PCWrite_o=0, IFID_Stall_o=1, IDEX_Stall_o=1, EXMEM_Stall_o=1, MEMWB_Bubble_o=1.
  - IDEX_Bubble_o=0 and IFID_Flush_o=0.
  - load_use and Branch_taken_i are ignored; they are re-evaluated after release.
- Priority, else load_use:
  - PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1.
  - IFID_Flush_o=0, because the branch in ID is re-evaluated next cycle with valid operands.
- Priority, else Branch_taken_i:
  - IFID_Flush_o=1; PCWrite_o=1.
- Otherwise: PCWrite_o=1 and all other control outputs are 0.
- MemStall_o = mem_stall.
- StallCnt_o increments by 1 on each non-reset cycle where mem_stall || load_use.
  - The increment counts a cycle, not a source: it is 1 even when both are true.
  - It holds at all-ones and never wraps.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding localparams ST_RUN=1'b0, ST_WAIT=1'b1;
  - REG_ZERO=5'd0.
- Natural sub-module: hazard_detect, a combinational load_use compare, reusable by the forwarding unit's bench.
- The FSM and counter stay in the top module.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with EXMEM_MemAccess_i=1 -> PCWrite_o=1, all other controls 0, StallCnt_o=0. After release, MemStall_o rises on the first cycle.
- Load-use: IDEX_MemRead_i=1, IDEX_RegAddrRt_i=8, IFID_RegAddrRs_i=8 -> for that cycle PCWrite_o=0, IFID_Stall_o=1, IDEX_Bubble_o=1, StallCnt_o +1. Repeat with Rt=0 -> no stall.
- Memory latency, MEM_LAT=3: EXMEM_MemAccess_i=1 from cycle t through t+2 -> MemStall_o=1 at t and t+1, 0 at t+2; EXMEM_Stall_o and MEMWB_Bubble_o track it. Repeat with MEM_LAT=1 -> no stall.
- Back-to-back accesses, MEM_LAT=2: EXMEM_MemAccess_i held high for 4 cycles -> stall pattern 1,0,1,0.
- Simultaneous events: Branch_taken_i=1 with load_use=1 -> IFID_Flush_o=0. Branch_taken_i=1 alone -> IFID_Flush_o=1, PCWrite_o=1. Any of these during mem_stall -> only the mem-stall outputs assert.
- Saturation, CNT_W=4: force 20 load-use cycles -> StallCnt_o reaches 15 and holds. Then assert rst_i mid-WAIT -> state RUN, counter 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller and its hazard helpers.
// Holds the memory-FSM state encoding and the bundle of per-stage control outputs.
package pipe_ctrl_pkg;

    localparam logic       ST_RUN   = 1'b0;
    localparam logic       ST_WAIT  = 1'b1;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_write;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_stall;
        logic idex_bubble;
        logic exmem_stall;
        logic memwb_bubble;
    } ctrl_t;

    // Free-running pipeline: only the PC advances on its own.
    localparam ctrl_t CTRL_IDLE = '{pc_write: 1'b1, default: 1'b0};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the source registers in ID.
// Purely combinational so other units (forwarding bench, etc.) can reuse it.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       IDEX_MemRead_i,
    input  logic [4:0] IDEX_RegAddrRt_i,
    input  logic [4:0] IFID_RegAddrRs_i,
    input  logic [4:0] IFID_RegAddrRt_i,
    output logic       LoadUse_o
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (IDEX_RegAddrRt_i == IFID_RegAddrRs_i);
    assign rt_match = (IDEX_RegAddrRt_i == IFID_RegAddrRt_i);

    // $zero is never a real producer, so a load targeting it cannot create a hazard.
    assign LoadUse_o = IDEX_MemRead_i && (IDEX_RegAddrRt_i != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush/bubble controller for the 5-stage pipeline: memory-latency FSM,
// load-use stalls and taken-branch flushes, plus a saturating stall-cycle counter.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RegAddrRt_i,
    input  logic [4:0]       IFID_RegAddrRs_i,
    input  logic [4:0]       IFID_RegAddrRt_i,
    input  logic             Branch_taken_i,
    input  logic             EXMEM_MemAccess_i,
    output logic             PCWrite_o,
    output logic             IFID_Stall_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Stall_o,
    output logic             IDEX_Bubble_o,
    output logic             EXMEM_Stall_o,
    output logic             MEMWB_Bubble_o,
    output logic             MemStall_o,
    output logic [CNT_W-1:0] StallCnt_o
);

    // Wait counter only needs to hold MEM_LAT-2; keep at least one bit.
    localparam int             CW       = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
    localparam logic [CW-1:0]  CNT_INIT = CW'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
    localparam bit             MEM_SLOW = (MEM_LAT > 1);

    logic             state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             fsm_stall;
    logic             mem_stall;
    logic             hazard_lu;
    logic             load_use;
    ctrl_t            ctrl;

    hazard_detect u_hazard_detect (
        .IDEX_MemRead_i   (IDEX_MemRead_i),
        .IDEX_RegAddrRt_i (IDEX_RegAddrRt_i),
        .IFID_RegAddrRs_i (IFID_RegAddrRs_i),
        .IFID_RegAddrRt_i (IFID_RegAddrRt_i),
        .LoadUse_o        (hazard_lu)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fsm_stall = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (EXMEM_MemAccess_i && MEM_SLOW) begin
                    fsm_stall = 1'b1;
                    cnt_d     = CNT_INIT;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // cnt==0 is the completion cycle: pipeline released, new access seen next cycle.
                if (cnt_q != '0) begin
                    fsm_stall = 1'b1;
                    cnt_d     = cnt_q - CW'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign mem_stall = fsm_stall && !rst_i;
    assign load_use  = hazard_lu && !rst_i;

    // One increment per stalled cycle, whichever source(s) caused it; saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((mem_stall || load_use) && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_comb begin
        ctrl = CTRL_IDLE;
        if (rst_i) begin
            ctrl = CTRL_IDLE;
        end else if (mem_stall) begin
            // Freeze everything upstream of MEM and drain a bubble into WB.
            ctrl.pc_write     = 1'b0;
            ctrl.ifid_stall   = 1'b1;
            ctrl.idex_stall   = 1'b1;
            ctrl.exmem_stall  = 1'b1;
            ctrl.memwb_bubble = 1'b1;
        end else if (load_use) begin
            // No flush: a branch in ID is re-resolved next cycle with the loaded operand.
            ctrl.pc_write    = 1'b0;
            ctrl.ifid_stall  = 1'b1;
            ctrl.idex_bubble = 1'b1;
        end else if (Branch_taken_i) begin
            ctrl.ifid_flush = 1'b1;
        end
    end

    assign PCWrite_o      = ctrl.pc_write;
    assign IFID_Stall_o   = ctrl.ifid_stall;
    assign IFID_Flush_o   = ctrl.ifid_flush;
    assign IDEX_Stall_o   = ctrl.idex_stall;
    assign IDEX_Bubble_o  = ctrl.idex_bubble;
    assign EXMEM_Stall_o  = ctrl.exmem_stall;
    assign MEMWB_Bubble_o = ctrl.memwb_bubble;
    assign MemStall_o     = mem_stall;
    assign StallCnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: three controller instances (MEM_LAT 3/2/1) share one stimulus stream;
// a reference model pushes expected outputs, a monitor pops and compares.
module tb_hazard_stall_ctrl;

    localparam int N = 3;
    localparam int LAT [N] = '{3, 2, 1};
    localparam int WID [N] = '{4, 32, 8};

    logic       clk = 1'b0;
    logic       rst;
    logic       mr;
    logic [4:0] rte, rs, rt;
    logic       br, acc;

    logic [7:0]  act_ctl [N];
    logic [31:0] act_cnt [N];

    typedef struct packed {
        logic [N-1:0][7:0]  ctl;
        logic [N-1:0][31:0] cnt;
    } exp_t;

    exp_t    sb_q[$];
    int      checks = 0;
    int      errors = 0;
    longint  m_busy [N];
    longint  m_cnt  [N];

    always #5 clk = ~clk;

    logic [3:0]  cnt0;
    logic [31:0] cnt1;
    logic [7:0]  cnt2;

    hazard_stall_ctrl #(.MEM_LAT(3), .CNT_W(4)) u0 (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(mr), .IDEX_RegAddrRt_i(rte),
        .IFID_RegAddrRs_i(rs), .IFID_RegAddrRt_i(rt), .Branch_taken_i(br), .EXMEM_MemAccess_i(acc),
        .PCWrite_o(act_ctl[0][7]), .IFID_Stall_o(act_ctl[0][6]), .IFID_Flush_o(act_ctl[0][5]),
        .IDEX_Stall_o(act_ctl[0][4]), .IDEX_Bubble_o(act_ctl[0][3]), .EXMEM_Stall_o(act_ctl[0][2]),
        .MEMWB_Bubble_o(act_ctl[0][1]), .MemStall_o(act_ctl[0][0]), .StallCnt_o(cnt0));

    hazard_stall_ctrl #(.MEM_LAT(2), .CNT_W(32)) u1 (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(mr), .IDEX_RegAddrRt_i(rte),
        .IFID_RegAddrRs_i(rs), .IFID_RegAddrRt_i(rt), .Branch_taken_i(br), .EXMEM_MemAccess_i(acc),
        .PCWrite_o(act_ctl[1][7]), .IFID_Stall_o(act_ctl[1][6]), .IFID_Flush_o(act_ctl[1][5]),
        .IDEX_Stall_o(act_ctl[1][4]), .IDEX_Bubble_o(act_ctl[1][3]), .EXMEM_Stall_o(act_ctl[1][2]),
        .MEMWB_Bubble_o(act_ctl[1][1]), .MemStall_o(act_ctl[1][0]), .StallCnt_o(cnt1));

    hazard_stall_ctrl #(.MEM_LAT(1), .CNT_W(8)) u2 (
        .clk_i(clk), .rst_i(rst), .IDEX_MemRead_i(mr), .IDEX_RegAddrRt_i(rte),
        .IFID_RegAddrRs_i(rs), .IFID_RegAddrRt_i(rt), .Branch_taken_i(br), .EXMEM_MemAccess_i(acc),
        .PCWrite_o(act_ctl[2][7]), .IFID_Stall_o(act_ctl[2][6]), .IFID_Flush_o(act_ctl[2][5]),
        .IDEX_Stall_o(act_ctl[2][4]), .IDEX_Bubble_o(act_ctl[2][3]), .EXMEM_Stall_o(act_ctl[2][2]),
        .MEMWB_Bubble_o(act_ctl[2][1]), .MemStall_o(act_ctl[2][0]), .StallCnt_o(cnt2));

    assign act_cnt[0] = {28'd0, cnt0};
    assign act_cnt[1] = cnt1;
    assign act_cnt[2] = {24'd0, cnt2};

    // Reference: m_busy = cycles left in the current access (stall cycles + completion cycle).
    task automatic model_step(input int k, output logic [7:0] ctl, output logic [31:0] cnt_now);
        bit     ms, lu;
        longint maxc;
        maxc    = (64'd1 << WID[k]) - 1;
        cnt_now = m_cnt[k][31:0];
        if (rst) begin
            ctl       = 8'b1000_0000;
            m_busy[k] = 0;
            m_cnt[k]  = 0;
            return;
        end
        if (m_busy[k] == 0) begin
            ms        = acc && (LAT[k] > 1);
            m_busy[k] = ms ? LAT[k] - 1 : 0;
        end else begin
            ms        = (m_busy[k] > 1);
            m_busy[k] = m_busy[k] - 1;
        end
        lu = mr && (rte != 0) && ((rte == rs) || (rte == rt));
        if (ms)      ctl = 8'b0101_0111;
        else if (lu) ctl = 8'b0100_1000;
        else if (br) ctl = 8'b1010_0000;
        else         ctl = 8'b1000_0000;
        if ((ms || lu) && m_cnt[k] < maxc) m_cnt[k] = m_cnt[k] + 1;
    endtask

    task automatic cyc(input bit r, input bit m, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] c, input bit bt, input bit ac);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; mr = m; rte = a; rs = b; rt = c; br = bt; acc = ac;
        for (int k = 0; k < N; k++) begin
            logic [7:0]  ctl;
            logic [31:0] cv;
            model_step(k, ctl, cv);
            e.ctl[k] = ctl;
            e.cnt[k] = cv;
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                for (int k = 0; k < N; k++) begin
                    checks++;
                    if (act_ctl[k] !== e.ctl[k]) begin
                        errors++;
                        $display("FAIL ctl[lat=%0d] t=%0t got=%b exp=%b", LAT[k], $time, act_ctl[k], e.ctl[k]);
                    end
                    checks++;
                    if (act_cnt[k] !== e.cnt[k]) begin
                        errors++;
                        $display("FAIL stallcnt[lat=%0d] t=%0t got=%0d exp=%0d", LAT[k], $time, act_cnt[k], e.cnt[k]);
                    end
                end
            end
        end
    end

    initial begin : driver
        int waited;
        rst = 1; mr = 0; rte = 0; rs = 0; rt = 0; br = 0; acc = 0;
        for (int k = 0; k < N; k++) begin m_busy[k] = 0; m_cnt[k] = 0; end
        repeat (2) @(posedge clk);

        // Reset dominates a pending access; access seen on the first free cycle.
        cyc(1, 1, 8, 8, 0, 1, 1);
        cyc(1, 1, 8, 8, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(4);

        // Load-use on rs, on rt, and the $zero exception.
        cyc(0, 1, 8, 8, 3, 0, 0);
        cyc(0, 1, 9, 2, 9, 0, 0);
        cyc(0, 1, 0, 0, 0, 0, 0);
        cyc(0, 0, 8, 8, 8, 0, 0);

        // Single access held for three cycles.
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // Back-to-back accesses.
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1);
        idle(3);

        // Branch vs load-use vs memory stall priorities.
        cyc(0, 1, 5, 5, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        cyc(0, 1, 5, 5, 0, 1, 1);
        cyc(0, 1, 5, 0, 5, 1, 0);
        cyc(0, 0, 0, 0, 0, 1, 0);
        idle(3);

        // Saturation of the narrow counter.
        for (int i = 0; i < 20; i++) cyc(0, 1, 7, 7, 7, 0, 0);

        // Reset in the middle of a WAIT, then no residual stall.
        cyc(0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0);
        idle(3);

        // Random mix with small register numbers to provoke collisions.
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));

        waited = 0;
        while (sb_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (sb_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d pending exp=0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
